// File: rtl/traffic_light_monitor.sv
// Monitor and lamp driver for the traffic_light controller state/count outputs.
// Checks sequence and dwell lengths, latches faults, counts completed cycles.
module traffic_light_monitor #(
    parameter int GREEN_T  = 10,
    parameter int YELLOW_T = 3,
    parameter int RED_T    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state_in,
    input  logic [3:0] count_in,
    input  logic       clr,
    output logic [2:0] ns_lamp,
    output logic [2:0] ew_lamp,
    output logic       synced,
    output logic       fault,
    output logic [2:0] err_code,
    output logic       viol,
    output logic [7:0] cycles
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FLT   = 2'd2
    } mst_t;

    localparam logic [3:0] GM1 = 4'(GREEN_T - 1);
    localparam logic [3:0] YM1 = 4'(YELLOW_T - 1);
    localparam logic [3:0] RM1 = 4'(RED_T - 1);

    localparam logic [2:0] LRED = 3'b100;
    localparam logic [2:0] LYEL = 3'b010;
    localparam logic [2:0] LGRN = 3'b001;

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_ILL   = 3'd1;
    localparam logic [2:0] E_TRANS = 3'd2;
    localparam logic [2:0] E_EARLY = 3'd3;
    localparam logic [2:0] E_OVER  = 3'd4;
    localparam logic [2:0] E_CNT   = 3'd5;

    mst_t       mst;
    logic [2:0] ps;
    logic [3:0] pc;

    logic [3:0] tm1;
    logic [2:0] nxt;
    logic       chg;
    logic       adv;
    logic       err;
    logic [2:0] code;
    logic [2:0] dns;
    logic [2:0] dew;
    logic       start;
    logic       wrap;

    always_comb begin
        unique case (ps)
            3'd0, 3'd3: tm1 = GM1;
            3'd1, 3'd4: tm1 = YM1;
            default:    tm1 = RM1;
        endcase
    end

    // Successor is (ps+1) mod 6, including for illegal previous codes.
    always_comb begin
        unique case (ps)
            3'd5:    nxt = 3'd0;
            3'd6:    nxt = 3'd1;
            3'd7:    nxt = 3'd2;
            default: nxt = ps + 3'd1;
        endcase
    end

    assign chg = (state_in != ps);
    assign adv = chg && (state_in == nxt);

    always_comb begin
        code = E_NONE;
        if (state_in > 3'd5)
            code = E_ILL;
        else if (chg && !adv)
            code = E_TRANS;
        else if (adv && (pc != tm1))
            code = E_EARLY;
        else if (!chg && (count_in > tm1))
            code = E_OVER;
        else if ((!chg && ({1'b0, count_in} != {1'b0, pc} + 5'd1)) ||
                 (chg && (count_in != 4'd0)))
            code = E_CNT;
    end

    assign err   = (code != E_NONE);
    assign start = (state_in == 3'd0) && (count_in == 4'd0);
    assign wrap  = (ps == 3'd5) && (state_in == 3'd0);

    always_comb begin
        dns = LRED;
        dew = LRED;
        unique case (state_in)
            3'd0:    dns = LGRN;
            3'd1:    dns = LYEL;
            3'd3:    dew = LGRN;
            3'd4:    dew = LYEL;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mst      <= SYNC;
            ps       <= 3'd0;
            pc       <= 4'd0;
            ns_lamp  <= LRED;
            ew_lamp  <= LRED;
            synced   <= 1'b0;
            fault    <= 1'b0;
            err_code <= E_NONE;
            viol     <= 1'b0;
            cycles   <= 8'd0;
        end else if (clr) begin
            mst      <= SYNC;
            ps       <= 3'd0;
            pc       <= 4'd0;
            ns_lamp  <= LRED;
            ew_lamp  <= LRED;
            synced   <= 1'b0;
            fault    <= 1'b0;
            err_code <= E_NONE;
            viol     <= 1'b0;
        end else begin
            unique case (mst)
                SYNC: begin
                    viol <= 1'b0;
                    if (start) begin
                        mst     <= TRACK;
                        ps      <= 3'd0;
                        pc      <= 4'd0;
                        synced  <= 1'b1;
                        ns_lamp <= LGRN;
                        ew_lamp <= LRED;
                    end
                end
                TRACK: begin
                    ps   <= state_in;
                    pc   <= count_in;
                    viol <= err;
                    if (err) begin
                        mst      <= FLT;
                        synced   <= 1'b0;
                        fault    <= 1'b1;
                        err_code <= code;
                        ns_lamp  <= LRED;
                        ew_lamp  <= LRED;
                    end else begin
                        ns_lamp <= dns;
                        ew_lamp <= dew;
                        if (wrap && (cycles != 8'hff))
                            cycles <= cycles + 8'd1;
                    end
                end
                default: begin
                    ps      <= state_in;
                    pc      <= count_in;
                    viol    <= err;
                    ns_lamp <= LRED;
                    ew_lamp <= LRED;
                end
            endcase
        end
    end

endmodule
